id_issue_stage: RTL and testbench
=================================

# id_issue_stage

Parametrised decode/issue pipeline stage for the MIPS core: owns the register file (NREG × DATA_W, register 0 hard-wired zero) and latches PC, instruction, decoded controls and up to NREAD operands into the ID/EX register under a valid/ready handshake. It sits between the fetch/decode logic, which supplies decoded controls and read numbers, and EX. Unlike the fixed two-port ID stage, it applies backpressure instead of forcing bubbles and keeps held operands coherent with late register writes. It also counts issue bubbles for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, register/operand width
- NREG, 32, register count (power of 2, ≥2); RW = $clog2(NREG)
- NREAD, 2, read ports (1..4)
- CON_W, 32, decoded control word width
- CON_NOP, 0, control word loaded on reset/flush/bubble

Ports:
- clk  in  1  clock
- clr  in  1  async active-high reset
- flush  in  1  sync squash of ID/EX contents
- in_valid  in  1  decode side offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc, in_ins  in  32 each  PC and raw instruction
- in_controls  in  CON_W  decoded controls
- in_ren  in  NREAD  per-port read enable
- in_rnum  in  NREAD*RW  read numbers, port k at [k*RW +: RW]
- wr_en  in  1  write-back enable (from MEM/WB)
- wr_num  in  RW  write register
- wr_data  in  DATA_W  write data
- rnum_realtime  out  NREAD*RW  combinational in_rnum, port forced 0 when in_ren[k]=0 or in_valid=0 (hazard unit)
- out_valid  out  1  ID/EX holds an instruction
- out_ready  in  1  EX consumes
- out_pc, out_ins  out  32 each
- out_controls  out  CON_W
- out_rnum  out  NREAD*RW  latched masked read numbers
- out_rdata  out  NREAD*DATA_W  latched operands
- bubble_cnt  out  32  saturating count of cycles with out_valid=0 after reset

## Operation
- Reset (clr=1, async): out_valid=0, out_pc=0, out_ins=0 (NOP), out_controls=CON_NOP, out_rnum=0, out_rdata=0, bubble_cnt=0, all registers=0.
- in_ready = !flush && (!out_valid || out_ready).
- Accept (in_valid && in_ready): latch pc, ins, controls, masked rnum and operand per port; out_valid=1.
- Operand k: 0 if in_ren[k]=0 or rnum=0; else register value (write bypass per Configuration).
- Drain without accept (out_valid && out_ready && !in_valid): out_valid=0, out_ins=0, out_controls=CON_NOP, out_rdata=0; out_pc keeps last value.
- Hold (out_valid && !out_ready): all fields stable except operand refresh: wr_en && wr_num≠0 && wr_num==out_rnum[k] with in_ren latched → out_rdata[k] ← wr_data next edge. Applies to every matching port.
- Flush: next edge out_valid=0, ins=0, controls=CON_NOP, rdata=0; overrides accept, hold and drain. Register writes still occur.
- Register file: write at posedge when wr_en && wr_num≠0; writes to 0 ignored.
- bubble_cnt increments each edge where out_valid=0 (current value), saturates at 0xFFFFFFFF.

## Timing
- Accept-to-out_valid latency: 1 cycle; full throughput (1/cycle) when out_ready=1.
- rnum_realtime and in_ready: combinational, same cycle.
- Write visible to a read issued in the same cycle only with bypass; without it, next cycle.
- Operand refresh takes effect the edge after the write; consumption and write in the same cycle: consumed value is pre-write (EX forwarding responsibility).
- clr deasserted mid-operation: first accept possible on the first edge after deassertion.

## Configuration
- ID_WRITE_BYPASS_EN defined: read with wr_en && wr_num==rnum≠0 in the accept cycle latches wr_data (write-first).
- Undefined: accept latches the pre-write array value; hold-refresh still active.

## Test plan
- Reset then write r5=0x1234_5678, next cycle accept ren=11, rnum0=5, rnum1=0 → out_rdata0=0x12345678, out_rdata1=0, out_valid=1 after 1 cycle.
- Same-cycle write r7=0xA5 and read r7: with ID_WRITE_BYPASS_EN → 0xA5; without → old value 0.
- out_ready=0 for 3 cycles, in_valid=1: in_ready=0, outputs stable; write r3=0x99 while out_rnum1=3 → out_rdata1=0x99 next cycle.
- Flush with in_valid=1, out_valid=1: next cycle out_valid=0, out_ins=0, out_controls=CON_NOP, input not accepted; bubble_cnt +1 per idle cycle.
- Back-to-back 8 accepts with out_ready=1 → 8 consecutive valid outputs, no bubbles; write to r0=0xFF then read → 0.
- Assert clr asynchronously mid-hold → outputs zero immediately, bubble_cnt=0, registers read 0.

Source files
------------

// File: rtl/id_issue_stage.sv
// id_issue_stage: decode/issue stage owning the register file and the ID/EX
// register. Valid/ready handshake with backpressure, operand refresh while an
// instruction is held, and a saturating bubble counter.
// Optional feature: define ID_WRITE_BYPASS_EN to make a write-back in the accept
// cycle visible to the operands being latched (write-first read).
module id_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned CON_W  = 32,
  parameter logic [CON_W-1:0] CON_NOP = '0,
  localparam int unsigned RW = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_pc,
  input  logic [31:0]             in_ins,
  input  logic [CON_W-1:0]        in_controls,
  input  logic [NREAD-1:0]        in_ren,
  input  logic [NREAD*RW-1:0]     in_rnum,
  input  logic                    wr_en,
  input  logic [RW-1:0]           wr_num,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [NREAD*RW-1:0]     rnum_realtime,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_ins,
  output logic [CON_W-1:0]        out_controls,
  output logic [NREAD*RW-1:0]     out_rnum,
  output logic [NREAD*DATA_W-1:0] out_rdata,
  output logic [31:0]             bubble_cnt
);

  logic [DATA_W-1:0]       regs [NREG];
  logic                    accept;
  logic [NREAD*DATA_W-1:0] rdata_issue;
  logic [NREAD*DATA_W-1:0] rdata_refresh;

  // Handshake: a flush blocks intake; otherwise accept when the slot is free or draining
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Read numbers masked by port enable and offer valid (also feeds the hazard unit)
  always_comb begin
    rnum_realtime = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      if (in_valid && in_ren[k]) begin
        rnum_realtime[k*RW +: RW] = in_rnum[k*RW +: RW];
      end
    end
  end

  // Operands for the instruction being issued; register 0 always reads zero
  always_comb begin
    rdata_issue = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      if (rnum_realtime[k*RW +: RW] != '0) begin
`ifdef ID_WRITE_BYPASS_EN
        if (wr_en && (wr_num == rnum_realtime[k*RW +: RW])) begin
          rdata_issue[k*DATA_W +: DATA_W] = wr_data;
        end else begin
          rdata_issue[k*DATA_W +: DATA_W] = regs[rnum_realtime[k*RW +: RW]];
        end
`else
        rdata_issue[k*DATA_W +: DATA_W] = regs[rnum_realtime[k*RW +: RW]];
`endif
      end
    end
  end

  // Held operands pick up late write-backs; a zero out_rnum means the port was unused
  always_comb begin
    rdata_refresh = out_rdata;
    for (int unsigned k = 0; k < NREAD; k++) begin
      if (wr_en && (wr_num != '0) && (wr_num == out_rnum[k*RW +: RW])) begin
        rdata_refresh[k*DATA_W +: DATA_W] = wr_data;
      end
    end
  end

  // ID/EX register: flush > accept > drain > hold-with-refresh
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_ins      <= '0;
      out_controls <= CON_NOP;
      out_rnum     <= '0;
      out_rdata    <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_ins      <= '0;
      out_controls <= CON_NOP;
      out_rdata    <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_ins      <= in_ins;
      out_controls <= in_controls;
      out_rnum     <= rnum_realtime;
      out_rdata    <= rdata_issue;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
      out_ins      <= '0;
      out_controls <= CON_NOP;
      out_rdata    <= '0;
    end else if (out_valid) begin
      out_rdata    <= rdata_refresh;
    end
  end

  // Register file; writes to register 0 are dropped so it stays zero
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_num != '0)) begin
      regs[wr_num] <= wr_data;
    end
  end

  // Saturating count of edges seen with an empty ID/EX register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed steps from the test plan plus a random
// phase, all checked against a cycle-level model of the stage kept here.
module tb_id_issue_stage;

  localparam int unsigned RW  = 5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clr, flush, in_valid, out_ready, wr_en;
  logic [31:0] in_pc, in_ins, in_controls, wr_data;
  logic [1:0]  in_ren;
  logic [9:0]  in_rnum;
  logic [4:0]  wr_num;
  logic        in_ready, out_valid;
  logic [9:0]  rnum_realtime, out_rnum;
  logic [31:0] out_pc, out_ins, out_controls, bubble_cnt;
  logic [63:0] out_rdata;

  id_issue_stage #(
    .DATA_W(32), .NREG(32), .NREAD(2), .CON_W(32), .CON_NOP(NOP)
  ) dut (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ins(in_ins), .in_controls(in_controls), .in_ren(in_ren),
    .in_rnum(in_rnum), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .rnum_realtime(rnum_realtime), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ins(out_ins), .out_controls(out_controls),
    .out_rnum(out_rnum), .out_rdata(out_rdata), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic        m_valid, m_pc_known;
  logic [31:0] m_pc, m_ins, m_con, m_bub;
  logic [4:0]  m_rnum [2];
  logic [31:0] m_rdata [2];
  logic [31:0] mregs [32];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_pc_known = 1'b1;
    m_pc = '0; m_ins = '0; m_con = NOP; m_bub = '0;
    for (int k = 0; k < 2; k++) begin m_rnum[k] = '0; m_rdata[k] = '0; end
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endtask

  function automatic logic [31:0] operand(input logic [4:0] rn);
    if (rn == 5'd0) return 32'd0;
`ifdef ID_WRITE_BYPASS_EN
    if (wr_en && wr_num == rn) return wr_data;
`endif
    return mregs[rn];
  endfunction

  task automatic check_outs();
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_pc_known) chk("out_pc", 64'(out_pc), 64'(m_pc));
    chk("out_ins", 64'(out_ins), 64'(m_ins));
    chk("out_controls", 64'(out_controls), 64'(m_con));
    if (m_valid) chk("out_rnum", 64'(out_rnum), 64'({m_rnum[1], m_rnum[0]}));
    chk("out_rdata", out_rdata, {m_rdata[1], m_rdata[0]});
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs
  task automatic tick();
    logic       exp_ready, acc;
    logic [9:0] exp_rt;
    logic [4:0] rn;
    #1;
    exp_ready = !flush && (!m_valid || out_ready);
    exp_rt = '0;
    for (int k = 0; k < 2; k++) if (in_valid && in_ren[k]) exp_rt[k*RW +: RW] = in_rnum[k*RW +: RW];
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("rnum_realtime", 64'(rnum_realtime), 64'(exp_rt));
    acc = in_valid && exp_ready;
    @(posedge clk);
    #1;
    if (!m_valid && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
    if (flush) begin
      m_valid = 0; m_ins = 0; m_con = NOP; m_pc_known = 0;
      m_rdata[0] = 0; m_rdata[1] = 0;
    end else if (acc) begin
      m_valid = 1; m_pc = in_pc; m_pc_known = 1; m_ins = in_ins; m_con = in_controls;
      for (int k = 0; k < 2; k++) begin
        rn = in_ren[k] ? in_rnum[k*RW +: RW] : 5'd0;
        m_rnum[k] = rn;
        m_rdata[k] = operand(rn);
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0; m_ins = 0; m_con = NOP;
      m_rdata[0] = 0; m_rdata[1] = 0;
    end else if (m_valid) begin
      for (int k = 0; k < 2; k++)
        if (wr_en && wr_num != 0 && wr_num == m_rnum[k]) m_rdata[k] = wr_data;
    end
    if (wr_en && wr_num != 0) mregs[wr_num] = wr_data;
    check_outs();
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 1; wr_en = 0; wr_num = 0; wr_data = 0;
    in_pc = 0; in_ins = 0; in_controls = 0; in_ren = 0; in_rnum = 0;
  endtask

  task automatic rand_inputs(input int unsigned flush_pct);
    in_valid    = ($urandom_range(0, 3) != 0);
    out_ready   = ($urandom_range(0, 2) != 0);
    flush       = ($urandom_range(0, 99) < flush_pct);
    in_pc       = $urandom;
    in_ins      = $urandom;
    in_controls = $urandom;
    in_ren      = 2'($urandom);
    in_rnum     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    wr_en       = 1'($urandom_range(0, 1));
    wr_num      = 5'($urandom_range(0, 7));
    wr_data     = $urandom;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [1:0] ren, input logic [4:0] r1, input logic [4:0] r0);
    in_valid = 1; in_pc = pc; in_ins = pc ^ 32'hA000_0000; in_controls = pc + 32'd7;
    in_ren = ren; in_rnum = {r1, r0};
  endtask

  initial begin
    logic [31:0] b0;
    clr = 1;
    idle_inputs();
    model_reset();
    #3;
    check_outs();
    @(posedge clk); #1;
    check_outs();
    clr = 0;

    // Write r5, then read it through port 0 with port 1 reading r0
    wr_en = 1; wr_num = 5'd5; wr_data = 32'h1234_5678;
    tick();
    wr_en = 0;
    offer(32'h100, 2'b11, 5'd0, 5'd5);
    tick();
    chk("tp1_rdata", out_rdata, {32'h0, 32'h1234_5678});
    chk("tp1_valid", 64'(out_valid), 64'd1);

    // Same-cycle write and read of r7
    wr_en = 1; wr_num = 5'd7; wr_data = 32'hA5;
    offer(32'h104, 2'b01, 5'd0, 5'd7);
    tick();
`ifdef ID_WRITE_BYPASS_EN
    chk("tp2_bypass", 64'(out_rdata[31:0]), 64'h0000_00A5);
`else
    chk("tp2_bypass", 64'(out_rdata[31:0]), 64'h0);
`endif
    wr_en = 0;

    // Hold for three cycles with a late write to r3 held in port 1
    offer(32'h108, 2'b10, 5'd3, 5'd0);
    tick();
    out_ready = 0;
    offer(32'h10C, 2'b11, 5'd1, 5'd2);
    tick();
    wr_en = 1; wr_num = 5'd3; wr_data = 32'h99;
    tick();
    chk("tp3_refresh", 64'(out_rdata[63:32]), 64'h99);
    wr_en = 0;
    tick();
    chk("tp3_pc_stable", 64'(out_pc), 64'h108);

    // Flush with a held instruction and a pending offer
    flush = 1;
    tick();
    chk("tp4_valid", 64'(out_valid), 64'd0);
    chk("tp4_ctl", 64'(out_controls), 64'(NOP));
    flush = 0; in_valid = 0; out_ready = 1;
    b0 = m_bub;
    repeat (3) tick();
    chk("tp4_bubbles", 64'(bubble_cnt), 64'(b0 + 32'd3));

    // Eight back-to-back accepts
    out_ready = 1;
    offer($urandom, 2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    tick();
    b0 = m_bub;
    for (int i = 0; i < 7; i++) begin
      offer($urandom, 2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end
    chk("tp5_no_bubbles", 64'(bubble_cnt), 64'(b0));
    in_valid = 0; wr_en = 1; wr_num = 5'd0; wr_data = 32'hFF;
    tick();
    wr_en = 0;
    offer(32'h200, 2'b01, 5'd0, 5'd0);
    tick();
    chk("tp5_r0", 64'(out_rdata[31:0]), 64'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs(5);
      tick();
    end

    // Asynchronous clear during a hold
    idle_inputs();
    offer(32'h300, 2'b11, 5'd3, 5'd5);
    tick();
    out_ready = 0;
    tick();
    #2;
    clr = 1;
    #1;
    model_reset();
    check_outs();
    #2;
    clr = 0;
    out_ready = 1;
    offer(32'h400, 2'b11, 5'd3, 5'd5);
    tick();
    chk("tp6_regs_zero", out_rdata, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
